tx_arbiter: RTL

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter_if.sv | 26 ++
 rtl/tx_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: requester/emitter bundle between two code requesters and tx_arbiter.
//   master: requester side, drives reqN_valid_in/reqN_code_in, observes every status output
//   slave : arbiter side, drives reqN_ready_out, signal_out, grant_out, busy_out, done_out, state_out
interface tx_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid_in;
   logic             req1_valid_in;
   logic [WIDTH-1:0] req0_code_in;
   logic [WIDTH-1:0] req1_code_in;
   logic             req0_ready_out;
   logic             req1_ready_out;
   logic             signal_out;
   logic [1:0]       grant_out;
   logic             busy_out;
   logic             done_out;
   logic [3:0]       state_out;
   modport master (
      output req0_valid_in, req1_valid_in, req0_code_in, req1_code_in,
      input  req0_ready_out, req1_ready_out, signal_out, grant_out, busy_out, done_out, state_out
   );
   modport slave (
      input  req0_valid_in, req1_valid_in, req0_code_in, req1_code_in,
      output req0_ready_out, req1_ready_out, signal_out, grant_out, busy_out, done_out, state_out
   );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter for two requesters feeding a pulse-distance code emitter.
//   clk_in   : single clock
//   rst_n_in : asynchronous active-low reset, deassertion synchronised internally
//   bus      : tx_arbiter_if.slave (valid/code/ready per requester, signal_out, grant_out,
//              busy_out, done_out, state_out)
// Frame: SYNC_H(SBD) SYNC_L(SSD) then per bit MSB first BIT_H(BBD) BIT_L(BSD0|BSD1), then STOP_H(BBD).
// Macro TX_GUARD_EN: when defined, STOP_H is followed by GUARD cycles of silence before IDLE.
module tx_arbiter #(
   parameter int SBD   = 800,
   parameter int SSD   = 800,
   parameter int BBD   = 400,
   parameter int BSD0  = 200,
   parameter int BSD1  = 400,
   parameter int WIDTH = 8,
   parameter int GUARD = 1000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   tx_arbiter_if.slave bus
);
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_SYNC_H = 4'd1,
      S_SYNC_L = 4'd2,
      S_BIT_H  = 4'd3,
      S_BIT_L  = 4'd4,
      S_STOP_H = 4'd5,
      S_GUARD  = 4'd6
   } state_t;
`ifdef TX_GUARD_EN
   localparam state_t POST_STOP = S_GUARD;
`else
   localparam state_t POST_STOP = S_IDLE;
`endif
   state_t           state_q, state_d;
   logic [1:0]       rst_sync_q;
   logic             rst_n_sync;
   logic [31:0]      cnt_q, cnt_d, dur, bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] code_q, code_d;
   logic [1:0]       grant_q, grant_d;
   logic             last_q, last_d, signal_q, signal_d;
   logic             idle_ok, pick1, hs, at_end;
   // Assertion is immediate; release reaches the core only after two edges, so the first
   // active edge always sees IDLE.
   always_ff @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) rst_sync_q <= 2'b00;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   assign rst_n_sync = rst_sync_q[1];
   always_ff @(posedge clk_in or negedge rst_n_sync)
      if (!rst_n_sync) state_q <= S_IDLE;
      else             state_q <= state_d;
   // last_q = 1 means req1 was granted last, so req0 wins the first contention after reset.
   always_ff @(posedge clk_in or negedge rst_n_sync)
      if (!rst_n_sync) begin
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         code_q    <= '0;
         grant_q   <= '0;
         last_q    <= 1'b1;
         signal_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         code_q    <= code_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         signal_q  <= signal_d;
      end
   // Length of the current state; BIT_L length follows the bit under transmission (code MSB).
   always_comb begin
      dur    = (state_q == S_SYNC_H) ? 32'(SBD) :
               (state_q == S_SYNC_L) ? 32'(SSD) :
               (state_q == S_BIT_L)  ? (code_q[WIDTH-1] ? 32'(BSD1) : 32'(BSD0)) :
               (state_q == S_GUARD)  ? 32'(GUARD) : 32'(BBD);
      at_end = cnt_q == dur - 32'd1;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = hs ? S_SYNC_H : S_IDLE;
         S_SYNC_H: state_d = at_end ? S_SYNC_L : S_SYNC_H;
         S_SYNC_L: state_d = at_end ? S_BIT_H : S_SYNC_L;
         S_BIT_H:  state_d = at_end ? S_BIT_L : S_BIT_H;
         S_BIT_L:  state_d = at_end ? ((bit_cnt_q == 32'(WIDTH - 1)) ? S_STOP_H : S_BIT_H) : S_BIT_L;
         S_STOP_H: state_d = at_end ? POST_STOP : S_STOP_H;
         S_GUARD:  state_d = at_end ? S_IDLE : S_GUARD;
         default:  state_d = S_IDLE;
      endcase
   end
   // Datapath next state: counter restarts on every state change, code shifts after each bit.
   always_comb begin
      cnt_d     = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 32'd1;
      code_d    = hs ? (pick1 ? bus.req1_code_in : bus.req0_code_in) :
                  (state_q == S_BIT_L && at_end) ? code_q << 1 : code_q;
      bit_cnt_d = hs ? '0 : (state_q == S_BIT_L && at_end) ? bit_cnt_q + 32'd1 : bit_cnt_q;
      grant_d   = hs ? {pick1, !pick1} : (state_d == S_IDLE) ? 2'b00 : grant_q;
      last_d    = hs ? pick1 : last_q;
      signal_d  = state_d inside {S_SYNC_H, S_BIT_H, S_STOP_H};
   end
   // Ready is gated by the synchronised reset so it stays low for the whole reset window.
   always_comb begin
      idle_ok            = state_q == S_IDLE && rst_n_sync;
      pick1              = bus.req1_valid_in && (!bus.req0_valid_in || !last_q);
      bus.req1_ready_out = idle_ok && pick1;
      bus.req0_ready_out = idle_ok && bus.req0_valid_in && !pick1;
      hs                 = bus.req0_ready_out || bus.req1_ready_out;
      bus.done_out       = state_q == S_STOP_H && at_end;
      bus.busy_out       = state_q != S_IDLE;
      bus.state_out      = state_q;
      bus.signal_out     = signal_q;
      bus.grant_out      = grant_q;
   end
endmodule
